pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard and stall controller for the 5-stage RISC-V core, sitting beside the ID stage. It generates per-stage write-enable and bubble (flush) controls from load-use, store→load, multiply/divide and memory-wait conditions, and from redirects (jump in ID, taken branch in EX or MEM). Unlike the previous combinational controller, it carries state across cycles:
- squashes an instruction fetch that is in flight when a redirect occurs;
- counts memory-wait cycles and raises a timeout;
- keeps saturating stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall controller for the 5-stage core, sitting beside ID.
//   It turns load-use, store->load, mul/div, memory-wait and redirect
//   conditions into per-stage write enables and bubble (NOP-insert) controls.
//   The controller also keeps state across cycles:
//     - a discard flag that squashes a fetch still in flight when a redirect
//       happens;
//     - a RUN/DWAIT FSM that counts consecutive dmem-wait cycles and raises a
//       sticky timeout;
//     - saturating performance counters for load-use stalls, memory stalls
//       and flushes.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   ifid_*                : operand usage of the instruction in ID
//   idex_*                : destination / memory kind of the instruction in EX
//   imem_ready, dmem_ready: 1 = memory request completes this cycle
//   muldiv_busy           : multi-cycle mul/div is holding EX
//   jump, pc_src          : redirect from ID / from the branch-resolving stage
//   write_*               : pipeline register enables
//   bubble_*              : load a NOP into the register
//   fetch_discard         : the fetch completing this cycle is stale
//   mem_timeout           : sticky dmem-timeout flag
//   cnt_*                 : saturating performance counters
//   fsm_state             : debug view of the RUN(0)/DWAIT(1) FSM
//
// Ready semantics: a memory port is "done" in any cycle its ready input is
// high; there is no separate valid, so a low ready simply means "still busy".
module pipeline_hazard_ctrl #(
  parameter int REG_AW           = 5,
  parameter int BRANCH_STAGE     = 1,
  parameter int STORE_LOAD_STALL = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  input  logic              ifid_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_memread,
  input  logic              idex_memwrite,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              muldiv_busy,
  input  logic              jump,
  input  logic              pc_src,
  output logic              write_pc,
  output logic              write_ifid,
  output logic              write_idex,
  output logic              write_exmem,
  output logic              write_memwb,
  output logic              bubble_ifid,
  output logic              bubble_idex,
  output logic              bubble_exmem,
  output logic              fetch_discard,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  cnt_load_use,
  output logic [CNT_W-1:0]  cnt_mem_stall,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic              fsm_state
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {RUN = 1'b0, DWAIT = 1'b1} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              discard;

  logic load_use;
  logic sl_conflict;
  logic r_stall;   // rule 2: dmem wait freezes everything
  logic r_flush;   // rule 3: redirect from the branch stage
  logic r_hazard;  // rule 5: load-use or store->load stall

  assign load_use = idex_memread && (idex_rd != '0) &&
                    ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
                     (ifid_use_rs2 && (idex_rd == ifid_rs2)));
  assign sl_conflict = (STORE_LOAD_STALL != 0) && ifid_memread && idex_memwrite;

  assign r_stall  = !reset && !dmem_ready;
  assign r_flush  = !reset && dmem_ready && pc_src;
  assign r_hazard = !reset && dmem_ready && !pc_src && !muldiv_busy &&
                    (load_use || sl_conflict);

  // The stale-fetch squash only overrides the lower-priority rules; reset,
  // a dmem freeze or a fresh redirect take precedence over it.
  assign fetch_discard = discard && imem_ready && !reset && dmem_ready && !pc_src;

  assign fsm_state = state;

  always_comb begin
    write_pc     = 1'b1;
    write_ifid   = 1'b1;
    write_idex   = 1'b1;
    write_exmem  = 1'b1;
    write_memwb  = 1'b1;
    bubble_ifid  = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    if (reset) begin
      {write_pc, write_ifid, write_idex, write_exmem, write_memwb} = 5'b00000;
      {bubble_ifid, bubble_idex, bubble_exmem} = 3'b111;
    end else if (!dmem_ready) begin
      // Frozen pipeline: pc_src/jump are held upstream and replayed later.
      {write_pc, write_ifid, write_idex, write_exmem, write_memwb} = 5'b00000;
    end else if (pc_src) begin
      write_pc     = 1'b1;
      bubble_ifid  = 1'b1;
      bubble_idex  = 1'b1;
      bubble_exmem = (BRANCH_STAGE == 1);
    end else begin
      if (muldiv_busy) begin
        write_pc     = 1'b0;
        write_ifid   = 1'b0;
        write_idex   = 1'b0;
        bubble_exmem = 1'b1;
      end else if (load_use || sl_conflict) begin
        write_pc    = 1'b0;
        write_ifid  = 1'b0;
        bubble_idex = 1'b1;
      end else if (jump) begin
        write_pc    = 1'b1;
        bubble_ifid = 1'b1;
      end else if (!imem_ready) begin
        write_pc    = 1'b0;
        bubble_ifid = 1'b1;
      end
      if (fetch_discard) begin
        write_pc    = 1'b0;
        bubble_ifid = 1'b1;
      end
    end
  end

  // Length of the current dmem-wait run, saturating at MEM_TIMEOUT.
  always_comb begin
    wait_nxt = '0;
    if (!dmem_ready) begin
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      wait_cnt      <= '0;
      mem_timeout   <= 1'b0;
      discard       <= 1'b0;
      cnt_load_use  <= '0;
      cnt_mem_stall <= '0;
      cnt_flush     <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!dmem_ready) state <= DWAIT;
        end
        DWAIT: begin
          if (dmem_ready) state <= RUN;
        end
        default: state <= RUN;
      endcase
      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_MAX) mem_timeout <= 1'b1;

      // A redirect with the fetch still outstanding marks that fetch stale;
      // a redirect while already stale keeps the flag.
      if (r_flush && !imem_ready) discard <= 1'b1;
      else if (fetch_discard)     discard <= 1'b0;

      if (r_hazard && (cnt_load_use != '1))  cnt_load_use  <= cnt_load_use + CNT_ONE;
      if (r_stall  && (cnt_mem_stall != '1)) cnt_mem_stall <= cnt_mem_stall + CNT_ONE;
      if (r_flush  && (cnt_flush != '1))     cnt_flush     <= cnt_flush + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (MEM stage branch with the
// store->load stall, EX stage branch without it), a rule-based reference
// model, a vector table, hand sequences for multi-cycle cases and random
// stimulus.
module tb_pipeline_hazard_ctrl;

  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  // ---------------- clock / reset block ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_use_rs1, ifid_use_rs2, ifid_memread;
  logic       idex_memread, idex_memwrite;
  logic       imem_ready, dmem_ready, muldiv_busy, jump, pc_src;

  logic [4:0]    wr1, wr0;
  logic [2:0]    bb1, bb0;
  logic          fd1, fd0, mt1, mt0, st1, st0;
  logic [CW-1:0] clu1, cms1, cfl1, clu0, cms0, cfl0;

  pipeline_hazard_ctrl #(.REG_AW(5), .BRANCH_STAGE(1), .STORE_LOAD_STALL(1),
                         .MEM_TIMEOUT(TMO), .CNT_W(CW)) u_dut1 (
    .clock(clock), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .ifid_memread(ifid_memread), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .muldiv_busy(muldiv_busy), .jump(jump), .pc_src(pc_src),
    .write_pc(wr1[4]), .write_ifid(wr1[3]), .write_idex(wr1[2]),
    .write_exmem(wr1[1]), .write_memwb(wr1[0]),
    .bubble_ifid(bb1[2]), .bubble_idex(bb1[1]), .bubble_exmem(bb1[0]),
    .fetch_discard(fd1), .mem_timeout(mt1),
    .cnt_load_use(clu1), .cnt_mem_stall(cms1), .cnt_flush(cfl1),
    .fsm_state(st1)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .BRANCH_STAGE(0), .STORE_LOAD_STALL(0),
                         .MEM_TIMEOUT(TMO), .CNT_W(CW)) u_dut0 (
    .clock(clock), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .ifid_memread(ifid_memread), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .muldiv_busy(muldiv_busy), .jump(jump), .pc_src(pc_src),
    .write_pc(wr0[4]), .write_ifid(wr0[3]), .write_idex(wr0[2]),
    .write_exmem(wr0[1]), .write_memwb(wr0[0]),
    .bubble_ifid(bb0[2]), .bubble_idex(bb0[1]), .bubble_exmem(bb0[0]),
    .fetch_discard(fd0), .mem_timeout(mt0),
    .cnt_load_use(clu0), .cnt_mem_stall(cms0), .cnt_flush(cfl0),
    .fsm_state(st0)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic use1, use2, ifmr, exmr, exmw, imr, dmr, md, jmp, pcs, rst;
  } in_t;

  typedef struct {
    in_t        i;
    logic [4:0] w;  // {pc, ifid, idex, exmem, memwb}
    logic [2:0] b;  // {ifid, idex, exmem}
  } vec_t;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Index 1 = u_dut1 (branch in MEM, store->load stall on),
  // index 0 = u_dut0 (branch in EX, store->load stall off).
  bit m_disc[2];
  int m_run[2];
  bit m_tmo[2];
  int m_lu[2], m_ms[2], m_fl[2];

  function automatic int rule_of(input in_t v, input int k);
    bit lu, sl;
    lu = v.exmr && (v.rd != 0) &&
         ((v.use1 && v.rd == v.rs1) || (v.use2 && v.rd == v.rs2));
    sl = (k == 1) && v.ifmr && v.exmw;
    if (v.rst)      return 1;
    if (!v.dmr)     return 2;
    if (v.pcs)      return 3;
    if (v.md)       return 4;
    if (lu || sl)   return 5;
    if (v.jmp)      return 6;
    if (!v.imr)     return 7;
    return 0;
  endfunction

  function automatic void model_out(input in_t v, input int k,
                                    output logic [4:0] w, output logic [2:0] b,
                                    output logic fd);
    int r;
    r = rule_of(v, k);
    case (r)
      1:       begin w = 5'b00000; b = 3'b111; end
      2:       begin w = 5'b00000; b = 3'b000; end
      3:       begin w = 5'b11111; b = {2'b11, (k == 1) ? 1'b1 : 1'b0}; end
      4:       begin w = 5'b00011; b = 3'b001; end
      5:       begin w = 5'b00111; b = 3'b010; end
      6:       begin w = 5'b11111; b = 3'b100; end
      7:       begin w = 5'b01111; b = 3'b100; end
      default: begin w = 5'b11111; b = 3'b000; end
    endcase
    fd = m_disc[k] && v.imr && (r == 0 || r >= 4);
    if (fd) begin
      w[4] = 1'b0;
      b[2] = 1'b1;
    end
  endfunction

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  function automatic void model_edge(input in_t v, input int k);
    int r;
    logic [4:0] w;
    logic [2:0] b;
    logic fd;
    r = rule_of(v, k);
    model_out(v, k, w, b, fd);
    if (r == 1) begin
      m_disc[k] = 0; m_run[k] = 0; m_tmo[k] = 0;
      m_lu[k] = 0; m_ms[k] = 0; m_fl[k] = 0;
    end else begin
      if (r == 3 && !v.imr) m_disc[k] = 1;
      else if (fd)          m_disc[k] = 0;
      m_run[k] = (r == 2) ? m_run[k] + 1 : 0;
      if (m_run[k] >= TMO) m_tmo[k] = 1;
      if (r == 5) m_lu[k] = sat(m_lu[k]);
      if (r == 2) m_ms[k] = sat(m_ms[k]);
      if (r == 3) m_fl[k] = sat(m_fl[k]);
    end
  endfunction

  // ---------------- driver tasks ----------------
  function automatic in_t idle();
    in_t v;
    v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = 5'd0;
    v.use1 = 0; v.use2 = 0; v.ifmr = 0; v.exmr = 0; v.exmw = 0;
    v.imr = 1; v.dmr = 1; v.md = 0; v.jmp = 0; v.pcs = 0; v.rst = 0;
    return v;
  endfunction

  task automatic drive(input in_t v);
    reset = v.rst;
    ifid_rs1 = v.rs1; ifid_rs2 = v.rs2; idex_rd = v.rd;
    ifid_use_rs1 = v.use1; ifid_use_rs2 = v.use2; ifid_memread = v.ifmr;
    idex_memread = v.exmr; idex_memwrite = v.exmw;
    imem_ready = v.imr; dmem_ready = v.dmr; muldiv_busy = v.md;
    jump = v.jmp; pc_src = v.pcs;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // One cycle: apply inputs after the edge, compare mid-cycle against the
  // model, then advance the model to the state the next edge will load.
  task automatic step(input in_t v);
    logic [4:0] w;
    logic [2:0] b;
    logic fd;
    @(posedge clock);
    #1 drive(v);
    #2;
    for (int k = 0; k < 2; k++) begin
      model_out(v, k, w, b, fd);
      chk($sformatf("u%0d_write", k), (k == 1) ? wr1 : wr0, w);
      chk($sformatf("u%0d_bubble", k), (k == 1) ? bb1 : bb0, b);
      chk($sformatf("u%0d_fetch_discard", k), (k == 1) ? fd1 : fd0, fd);
      chk($sformatf("u%0d_mem_timeout", k), (k == 1) ? mt1 : mt0, m_tmo[k]);
      chk($sformatf("u%0d_cnt_load_use", k), (k == 1) ? clu1 : clu0, m_lu[k]);
      chk($sformatf("u%0d_cnt_mem_stall", k), (k == 1) ? cms1 : cms0, m_ms[k]);
      chk($sformatf("u%0d_cnt_flush", k), (k == 1) ? cfl1 : cfl0, m_fl[k]);
    end
    for (int k = 0; k < 2; k++) model_edge(v, k);
  endtask

  task automatic do_reset();
    in_t v;
    v = idle(); v.rst = 1;
    step(v);
    chk("reset_write", wr1, 5'b00000);
    chk("reset_bubble", bb1, 3'b111);
  endtask

  vec_t tbl[$];

  task automatic add(input in_t v, input logic [4:0] w, input logic [2:0] b);
    vec_t e;
    e.i = v; e.w = w; e.b = b;
    tbl.push_back(e);
  endtask

  initial begin
    in_t v, lu;
    for (int k = 0; k < 2; k++) begin
      m_disc[k] = 0; m_run[k] = 0; m_tmo[k] = 0;
      m_lu[k] = 0; m_ms[k] = 0; m_fl[k] = 0;
    end
    v = idle(); v.rst = 1;
    drive(v);

    // Load-use template: load to x5 in EX, ID reads x5 through rs2.
    lu = idle(); lu.exmr = 1; lu.rd = 5'd5; lu.rs2 = 5'd5; lu.use2 = 1;

    // ---- vector table (expectations for the MEM-branch instance) ----
    v = idle();                                              add(v, 5'b11111, 3'b000);
    add(lu, 5'b00111, 3'b010);
    v = idle(); v.exmr = 1; v.rd = 7; v.rs1 = 7; v.use1 = 1; add(v, 5'b00111, 3'b010);
    v = idle(); v.exmr = 1; v.rd = 0; v.rs1 = 0; v.use1 = 1; add(v, 5'b11111, 3'b000);
    v = idle(); v.exmr = 1; v.rd = 7; v.rs1 = 7;             add(v, 5'b11111, 3'b000);
    v = idle(); v.rd = 7; v.rs1 = 7; v.use1 = 1;             add(v, 5'b11111, 3'b000);
    v = idle(); v.ifmr = 1; v.exmw = 1;                      add(v, 5'b00111, 3'b010);
    v = idle(); v.md = 1;                                    add(v, 5'b00011, 3'b001);
    v = lu; v.md = 1;                                        add(v, 5'b00011, 3'b001);
    v = idle(); v.pcs = 1;                                   add(v, 5'b11111, 3'b111);
    v = lu; v.pcs = 1;                                       add(v, 5'b11111, 3'b111);
    v = idle(); v.pcs = 1; v.md = 1;                         add(v, 5'b11111, 3'b111);
    v = idle(); v.dmr = 0; v.pcs = 1;                        add(v, 5'b00000, 3'b000);
    v = idle(); v.jmp = 1;                                   add(v, 5'b11111, 3'b100);
    v = lu; v.jmp = 1;                                       add(v, 5'b00111, 3'b010);
    v = idle(); v.imr = 0;                                   add(v, 5'b01111, 3'b100);
    v = idle(); v.imr = 0; v.jmp = 1;                        add(v, 5'b11111, 3'b100);
    v = idle(); v.dmr = 0; v.md = 1;                         add(v, 5'b00000, 3'b000);

    do_reset();
    step(idle());
    chk("post_reset_fetch_discard", fd1, 0);
    chk("post_reset_mem_timeout", mt1, 0);
    chk("post_reset_cnt_sum", clu1 + cms1 + cfl1, 0);

    foreach (tbl[n]) begin
      step(tbl[n].i);
      chk($sformatf("vec%0d_write", n), wr1, tbl[n].w);
      chk($sformatf("vec%0d_bubble", n), bb1, tbl[n].b);
    end

    // ---- load-use counting, x0 never stalls ----
    do_reset();
    step(lu);
    v = lu; v.rd = 0; v.rs2 = 0;
    step(v);
    chk("lu_x0_write_pc", wr1[4], 1);
    chk("lu_cnt_one", clu1, 1);
    step(idle());
    chk("lu_cnt_still_one", clu1, 1);

    // ---- dmem wait with timeout at 4 ----
    do_reset();
    v = idle(); v.dmr = 0;
    for (int n = 0; n < TMO; n++) begin
      step(v);
      chk($sformatf("dwait%0d_write", n), wr1, 5'b00000);
      chk($sformatf("dwait%0d_timeout_low", n), mt1, 0);
    end
    step(idle());
    chk("dwait_cnt_mem_stall", cms1, 4);
    chk("dwait_timeout_set", mt1, 1);
    step(idle());
    chk("dwait_timeout_sticky", mt1, 1);

    // ---- redirect with fetch in flight ----
    do_reset();
    v = idle(); v.pcs = 1; v.imr = 0;
    step(v);
    chk("flush_bubbles", bb1, 3'b111);
    chk("flush_write_pc", wr1[4], 1);
    chk("flush_ex_branch_no_exmem_bubble", bb0[0], 0);
    v = idle(); v.imr = 0;
    for (int n = 0; n < 3; n++) step(v);
    step(idle());
    chk("discard_fetch_discard", fd1, 1);
    chk("discard_bubble_ifid", bb1[2], 1);
    chk("discard_write_pc", wr1[4], 0);
    step(idle());
    chk("discard_cleared", fd1, 0);
    chk("discard_cleared_write_pc", wr1[4], 1);

    // ---- dmem stall beats flush; flush replays afterwards ----
    do_reset();
    v = idle(); v.dmr = 0; v.pcs = 1;
    step(v);
    chk("stall_flush_bubbles", bb1, 3'b000);
    v.dmr = 1;
    step(v);
    chk("stall_flush_cnt_zero", cfl1, 0);
    chk("stall_flush_applied", bb1, 3'b111);
    step(idle());
    chk("stall_flush_cnt_one", cfl1, 1);

    // ---- muldiv for 3 cycles ----
    v = idle(); v.md = 1;
    for (int n = 0; n < 3; n++) begin
      step(v);
      chk($sformatf("muldiv%0d_write", n), wr1[4:2], 3'b000);
      chk($sformatf("muldiv%0d_bubble_exmem", n), bb1[0], 1);
    end

    // ---- reset while discard is pending ----
    do_reset();
    step(lu);
    v = idle(); v.pcs = 1; v.imr = 0;
    step(v);
    do_reset();
    chk("rst_mid_discard_fd", fd1, 0);
    step(idle());
    chk("rst_mid_discard_fd_after", fd1, 0);
    chk("rst_mid_discard_counters", {clu1, cms1, cfl1}, 0);

    // ---- counter saturation ----
    for (int n = 0; n < CMAX + 3; n++) step(lu);
    step(idle());
    chk("lu_saturated", clu1, CMAX);

    // ---- random stimulus against the model ----
    for (int n = 0; n < 600; n++) begin
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.rd   = 5'($urandom_range(0, 3));
      v.use1 = 1'($urandom_range(0, 1));
      v.use2 = 1'($urandom_range(0, 1));
      v.ifmr = 1'($urandom_range(0, 1));
      v.exmr = 1'($urandom_range(0, 1));
      v.exmw = 1'($urandom_range(0, 1));
      v.imr  = ($urandom_range(0, 3) != 0);
      v.dmr  = ((n % 100) < 7) ? 1'b0 : ($urandom_range(0, 9) != 0);
      v.md   = ($urandom_range(0, 7) == 0);
      v.jmp  = ($urandom_range(0, 5) == 0);
      v.pcs  = ($urandom_range(0, 5) == 0);
      v.rst  = ($urandom_range(0, 80) == 0);
      step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
